// File: rtl/snoop_ctrl_pkg.sv
// Shared types and helpers for the snoop controller.
// - state_e: FSM states of the snoop sequencer.
// - tag_word_t: widest possible tag-array word ({valid, tag}), used to pass
//   words of any configured width to the field-split helpers.
// - calc_tag_w / word_valid / word_tag: tag-word geometry and field split.
// CACHE_ADDR_WIDTH defaults to 32 unless the build defines it.

`ifndef CACHE_ADDR_WIDTH
`define CACHE_ADDR_WIDTH 32
`endif

package snoop_ctrl_pkg;

  localparam int unsigned AddrW    = `CACHE_ADDR_WIDTH;
  localparam int unsigned WordMaxW = AddrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCmp,
    StInv,
    StDone
  } state_e;

  typedef logic [WordMaxW-1:0] tag_word_t;

  function automatic int unsigned calc_tag_w(int unsigned idx_w, int unsigned ofs_w);
    return AddrW - idx_w - ofs_w;
  endfunction

  // Valid bit sits directly above the tag field.
  function automatic logic word_valid(tag_word_t word, int unsigned tag_w);
    tag_word_t shifted;
    shifted = word >> tag_w;
    return shifted[0];
  endfunction

  function automatic tag_word_t word_tag(tag_word_t word, int unsigned tag_w);
    tag_word_t mask;
    mask = '1;
    return word & (mask >> (WordMaxW - tag_w));
  endfunction

endpackage

// File: rtl/snoop_ctrl_if.sv
// Bus bundle for snoop_ctrl: SCU snoop channel, core tag-port request,
// shared tag-array port and the invalidation statistic.
// - slave:  view of the snoop controller.
// - master: view of the surrounding system (SCU, core, tag RAM).

interface snoop_ctrl_if #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned OFS_W = 4
);
  import snoop_ctrl_pkg::*;

  localparam int unsigned TAG_W = calc_tag_w(IDX_W, OFS_W);

  // SCU snoop channel
  logic [AddrW-1:0] snp_addr;
  logic             snp_valid;
  logic             snp_ready;

  // Core side of the tag port
  logic             core_req;
  logic             core_gnt;
  logic             core_tag_cs;
  logic             core_tag_we;
  logic [IDX_W-1:0] core_tag_idx;
  logic [TAG_W:0]   core_tag_wdata;

  // Shared tag-array port
  logic             tag_cs;
  logic             tag_we;
  logic [IDX_W-1:0] tag_idx;
  logic [TAG_W:0]   tag_wdata;
  logic [TAG_W:0]   tag_rdata;

  logic [31:0]      snp_hit_cnt;

  modport slave (
    input  snp_addr, snp_valid, core_req, core_tag_cs, core_tag_we, core_tag_idx,
           core_tag_wdata, tag_rdata,
    output snp_ready, core_gnt, tag_cs, tag_we, tag_idx, tag_wdata, snp_hit_cnt
  );

  modport master (
    output snp_addr, snp_valid, core_req, core_tag_cs, core_tag_we, core_tag_idx,
           core_tag_wdata, tag_rdata,
    input  snp_ready, core_gnt, tag_cs, tag_we, tag_idx, tag_wdata, snp_hit_cnt
  );

endinterface

// File: rtl/snoop_ctrl.sv
// Snoop controller: arbitrates the single tag-array port between the core and
// SCU snoops, looks up the snooped line and invalidates it on a hit.
// Ports:
//   clk  - clock, all state on the rising edge
//   rstn - asynchronous active-low reset
//   bus  - snoop_ctrl_if.slave (snoop channel, core request, tag port, stats)
// Sequence per snoop: IDLE (take) -> RD -> CMP -> [INV] -> DONE -> IDLE.
// The core only loses IDLE to a pending snoop after STARVE_MAX lost cycles.
// Build option: SNOOP_STAT_EN adds a 32-bit invalidation counter; without it
// snp_hit_cnt is tied to zero.

module snoop_ctrl
  import snoop_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned OFS_W      = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rstn,
  snoop_ctrl_if.slave bus
);

  localparam int unsigned TAG_W  = calc_tag_w(IDX_W, OFS_W);
  localparam int unsigned LineW  = IDX_W + TAG_W;
  localparam int unsigned CntW   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned PadW   = WordMaxW - (TAG_W + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  state_e           state_q, state_d;
  logic [LineW-1:0] line_q, line_d;     // snooped address without the byte offset
  logic [CntW-1:0]  starve_q, starve_d;
  logic             snp_take;
  logic             hit;

  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  tag_word_t        rd_word;
  logic             unused_ofs;

  assign lat_idx    = line_q[IDX_W-1:0];
  assign lat_tag    = line_q[LineW-1:IDX_W];
  assign unused_ofs = ^bus.snp_addr[OFS_W-1:0];

  assign rd_word = {{PadW{1'b0}}, bus.tag_rdata};
  assign hit     = word_valid(rd_word, TAG_W) &&
                   (word_tag(rd_word, TAG_W) == {{(WordMaxW - TAG_W){1'b0}}, lat_tag});

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    starve_d = starve_q;
    snp_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        snp_take = bus.snp_valid && (!bus.core_req || starve_q == StarveMax);
        if (snp_take) begin
          state_d  = StRd;
          line_d   = bus.snp_addr[AddrW-1:OFS_W];
          starve_d = '0;
        end else if (bus.snp_valid && bus.core_req) begin
          // Not taken with both requesting implies starve_q < StarveMax.
          starve_d = starve_q + 1'b1;
        end
      end
      StRd:    state_d = StCmp;
      StCmp:   state_d = hit ? StInv : StDone;
      StInv:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      line_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      starve_q <= starve_d;
    end
  end

  // Outputs decode the state flop; rstn gating keeps them at reset values while
  // reset is held even if the core is requesting.
  always_comb begin
    bus.core_gnt  = 1'b0;
    bus.tag_cs    = 1'b0;
    bus.tag_we    = 1'b0;
    bus.tag_idx   = '0;
    bus.tag_wdata = '0;
    bus.snp_ready = 1'b0;
    if (rstn) begin
      unique case (state_q)
        StIdle: begin
          if (bus.core_req && !snp_take) begin
            bus.core_gnt  = 1'b1;
            bus.tag_cs    = bus.core_tag_cs;
            bus.tag_we    = bus.core_tag_we;
            bus.tag_idx   = bus.core_tag_idx;
            bus.tag_wdata = bus.core_tag_wdata;
          end
        end
        StRd: begin
          bus.tag_cs  = 1'b1;
          bus.tag_idx = lat_idx;
        end
        StInv: begin
          bus.tag_cs  = 1'b1;
          bus.tag_we  = 1'b1;
          bus.tag_idx = lat_idx;
        end
        StDone:  bus.snp_ready = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SNOOP_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (state_q == StInv) hit_cnt_d = hit_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hit_cnt_q <= '0;
    else       hit_cnt_q <= hit_cnt_d;
  end

  assign bus.snp_hit_cnt = hit_cnt_q;
`else
  assign bus.snp_hit_cnt = 32'd0;
`endif

endmodule
